weighted_round_robin_arbiter: RTL and testbench

- Shares one resource between SIZE requesters. Each grant can last several cycles.
- A granted requester keeps the resource while its request stays high, up to a per-requester weight (burst length). Ownership then rotates to the next requester in round-robin order.
- Grant outputs are registered. Intended to sit in front of shared buses, memory ports and FIFOs that need fair, burst-aware access.

---
 rtl/weighted_round_robin_arbiter.sv | 106 ++++++++++
 tb/tb_weighted_round_robin_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_round_robin_arbiter.sv
// Burst-aware round-robin arbiter: the owner keeps the grant while requesting,
// up to its latched weight, then ownership rotates starting after the last owner.
module weighted_round_robin_arbiter #(
    parameter int SIZE         = 4,
    parameter int WEIGHT_WIDTH = 4,
    localparam int IDX_W       = $clog2(SIZE)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [SIZE-1:0]              requests,
    input  logic [SIZE*WEIGHT_WIDTH-1:0] weights,
    output logic [SIZE-1:0]              grant,
    output logic                         grant_valid,
    output logic [IDX_W-1:0]             grant_index
);

    localparam int CW = WEIGHT_WIDTH + 1;

    logic                    active_q, active_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_owner_q, last_owner_d;
    logic [WEIGHT_WIDTH-1:0] burst_count_q, burst_count_d;
    logic [WEIGHT_WIDTH-1:0] burst_limit_q, burst_limit_d;

    logic [WEIGHT_WIDTH-1:0] eff_weight [SIZE];
    logic                    hold;
    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        cand;

    // Offsets run 1..SIZE so the last owner itself is the final candidate.
    function automatic logic [IDX_W-1:0] wrap_index(input logic [IDX_W-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= SIZE) sum = sum - SIZE;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            eff_weight[i] = weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            if (eff_weight[i] == '0) eff_weight[i] = WEIGHT_WIDTH'(1);
        end
    end

    assign hold = active_q && requests[owner_q] &&
                  ((CW'(burst_count_q) + CW'(1)) < CW'(burst_limit_q));

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= SIZE; i++) begin
            cand = wrap_index(last_owner_q, i);
            if (!found && requests[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        active_d      = active_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        burst_count_d = burst_count_q;
        burst_limit_d = burst_limit_q;
        if (hold) begin
            burst_count_d = burst_count_q + WEIGHT_WIDTH'(1);
        end else if (found) begin
            active_d      = 1'b1;
            owner_d       = winner;
            last_owner_d  = winner;
            burst_count_d = '0;
            burst_limit_d = eff_weight[winner];
        end else begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q      <= 1'b0;
            owner_q       <= '0;
            last_owner_q  <= IDX_W'(SIZE - 1);
            burst_count_q <= '0;
            burst_limit_q <= '0;
        end else begin
            active_q      <= active_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            burst_count_q <= burst_count_d;
            burst_limit_q <= burst_limit_d;
        end
    end

    always_comb begin
        grant = '0;
        if (active_q) grant[owner_q] = 1'b1;
    end

    assign grant_valid = active_q;
    assign grant_index = active_q ? owner_q : '0;

endmodule

// File: tb/tb_weighted_round_robin_arbiter.sv
// Bench for weighted_round_robin_arbiter: a SIZE=4 instance checked every cycle
// against a remaining-cycles model, plus a SIZE=3 instance with directed checks.
module tb_weighted_round_robin_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  requests;
    logic [15:0] weights;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_index;

    logic [2:0]  requests3;
    logic [11:0] weights3;
    logic [2:0]  grant3;
    logic        grant_valid3;
    logic [1:0]  grant_index3;

    int tests = 0;
    int fails = 0;

    weighted_round_robin_arbiter #(.SIZE(4), .WEIGHT_WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests),
        .weights     (weights),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    weighted_round_robin_arbiter #(.SIZE(3), .WEIGHT_WIDTH(4)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests3),
        .weights     (weights3),
        .grant       (grant3),
        .grant_valid (grant_valid3),
        .grant_index (grant_index3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: owner plus number of grant cycles still owed in the current burst.
    int m_active, m_owner, m_last, m_left;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 0;
            m_owner  = 0;
            m_last   = 3;
            m_left   = 0;
        end else if (m_active == 1 && requests[m_owner] && m_left > 1) begin
            m_left = m_left - 1;
        end else begin
            int pick;
            pick = -1;
            for (int k = 1; k <= 4; k++) begin
                if (pick < 0 && requests[(m_last + k) % 4]) pick = (m_last + k) % 4;
            end
            if (pick >= 0) begin
                int w;
                w        = int'(weights[pick*4 +: 4]);
                m_active = 1;
                m_owner  = pick;
                m_last   = pick;
                m_left   = (w == 0) ? 1 : w;
            end else begin
                m_active = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic [3:0] exp_g;
        exp_g = (m_active == 1) ? (4'b0001 << m_owner) : 4'b0000;
        check("model_grant", 32'(grant), 32'(exp_g));
        check("model_valid", 32'(grant_valid), 32'(m_active));
        check("model_index", 32'(grant_index), (m_active == 1) ? m_owner : 0);
        check("size3_onehot0", 32'($onehot0(grant3)), 32'd1);
        check("size3_index_range", 32'(grant_index3 <= 2'd2), 32'd1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset     = 1'b1;
        requests  = 4'b0000;
        requests3 = 3'b000;
        #1;
        check("reset_async_grant", 32'(grant), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    logic [3:0] seq1 [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] idx1 [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] seq2 [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                              4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [2:0] seq5 [4]  = '{3'b001, 3'b100, 3'b001, 3'b100};

    initial begin
        reset     = 1'b1;
        requests  = 4'b0000;
        requests3 = 3'b000;
        weights   = 16'h1111;
        weights3  = 12'h111;
        repeat (2) @(posedge clock);
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_index", 32'(grant_index), 32'd0);
        check("reset_grant3", 32'(grant3), 32'd0);
        reset = 1'b0;

        // Equal weights: plain rotation, first grant one edge after request.
        requests = 4'b1111;
        #1;
        check("t1_no_same_cycle_grant", 32'(grant), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_grant", 32'(grant), 32'(seq1[i]));
            check("t1_index", 32'(grant_index), 32'(idx1[i]));
        end

        // Mixed weights including a zero weight.
        do_reset();
        weights  = 16'h0213;
        requests = 4'b1111;
        for (int i = 0; i < 11; i++) begin
            tick();
            check("t2_grant", 32'(grant), 32'(seq2[i]));
        end

        // Sole requester is re-granted seamlessly at each burst boundary.
        do_reset();
        weights  = 16'h0200;
        requests = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_sole_grant", 32'(grant), 32'b0100);
            check("t3_sole_valid", 32'(grant_valid), 32'd1);
        end

        // Owner drops mid-burst: handover on the same edge, then release.
        do_reset();
        weights  = 16'h0080;
        requests = 4'b0010;
        tick();
        check("t4_owner1", 32'(grant), 32'b0010);
        requests = 4'b1010;
        tick();
        check("t4_hold_a", 32'(grant), 32'b0010);
        tick();
        check("t4_hold_b", 32'(grant), 32'b0010);
        requests = 4'b1000;
        tick();
        check("t4_handover", 32'(grant), 32'b1000);
        check("t4_handover_idx", 32'(grant_index), 32'd3);
        requests = 4'b0000;
        tick();
        check("t4_release_grant", 32'(grant), 32'd0);
        check("t4_release_valid", 32'(grant_valid), 32'd0);

        // Non-power-of-two size skips idle index 1 and wraps.
        do_reset();
        requests3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_grant3", 32'(grant3), 32'(seq5[i]));
            check("t5_index3", 32'(grant_index3), (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        requests3 = 3'b000;

        // Reset in the middle of a burst clears outputs without a clock edge.
        do_reset();
        weights  = 16'h0300;
        requests = 4'b0100;
        tick();
        check("t6_grant_a", 32'(grant), 32'b0100);
        tick();
        check("t6_grant_b", 32'(grant), 32'b0100);
        #1;
        reset = 1'b1;
        #1;
        check("t6_async_grant", 32'(grant), 32'd0);
        check("t6_async_valid", 32'(grant_valid), 32'd0);
        @(posedge clock);
        #1;
        reset    = 1'b0;
        requests = 4'b1100;
        #1;
        check("t6_idle_after_release", 32'(grant), 32'd0);
        tick();
        check("t6_restart_grant", 32'(grant), 32'b0100);
        check("t6_restart_index", 32'(grant_index), 32'd2);

        requests = 4'b0000;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
